// File: rtl/mc_controller.sv
// mc_controller: multicycle main control FSM for the MIPS-style core.
// Steps each instruction through fetch/decode/execute/memory/writeback from
// the 6-bit opcode and drives the datapath enables, mux selects and aluop.
//
// Build option: MC_ILLEGAL_TRAP_EN
//   defined   -> an unrecognised opcode parks the FSM in HALT (halted=1)
//                until reset is asserted.
//   undefined -> an unrecognised opcode is a 2-cycle NOP; halted is tied 0.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   op[5:0]   in   opcode (instr[31:26]), sampled in DECODE and MEMADR
//   zero      in   ALU zero flag, same cycle
//   pcen      out  PC write enable (combinational on zero)
//   irwrite   out  instruction register load
//   regwrite  out  register file write
//   memwrite  out  data memory write
//   iord      out  memory address select (0 PC, 1 ALUOut)
//   alusrca   out  SrcA select (0 PC, 1 A)
//   alusrcb   out  SrcB select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   pcsrc     out  PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   regdst    out  destination register (0 rt, 1 rd)
//   memtoreg  out  writeback source (0 ALUOut, 1 Data)
//   aluop     out  ALU operation class for aludec
//   state     out  current state (debug)
//   halted    out  illegal-opcode halt flag
// All outputs are decodes of the state register and are forced to 0 while
// reset is low.

module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] aluop,
  output logic [3:0] state,
  output logic       halted
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_BLT   = 6'b011000;
  localparam logic [OP_W-1:0] OP_LI    = 6'b011001;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    LUIEX   = 4'd12,
    BLTEX   = 4'd13,
    LIEX    = 4'd14,
    HALT    = 4'd15
  } state_t;

  state_t state_r, state_nxt;
  logic   pcwrite, branch, bltbranch;

  // State register; reset aborts the current instruction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= FETCH;
    else        state_r <= state_nxt;
  end

  assign state = state_r;

  // Next-state and Moore output decode.
  always_comb begin
    state_nxt = state_r;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    bltbranch = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    iord      = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    aluop     = 3'b000;
    halted    = 1'b0;
    pcen      = 1'b0;

    case (state_r)
      FETCH: begin
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
        state_nxt = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
          OP_LUI:       state_nxt = LUIEX;
          OP_BLT:       state_nxt = BLTEX;
          OP_LI:        state_nxt = LIEX;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_nxt = HALT;
`else
          default:      state_nxt = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        state_nxt = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        memwrite  = 1'b1;
        state_nxt = FETCH;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = 3'b010;
        state_nxt = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        state_nxt = FETCH;
      end
      BEQEX: begin
        alusrca   = 1'b1;
        aluop     = 3'b001;
        pcsrc     = 2'b01;
        branch    = 1'b1;
        state_nxt = FETCH;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = ADDIWB;
      end
      ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      JEX: begin
        pcsrc     = 2'b10;
        pcwrite   = 1'b1;
        state_nxt = FETCH;
      end
      LUIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluop     = 3'b011;
        state_nxt = ADDIWB;
      end
      BLTEX: begin
        alusrca   = 1'b1;
        aluop     = 3'b110;
        pcsrc     = 2'b01;
        bltbranch = 1'b1;
        state_nxt = FETCH;
      end
      LIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluop     = 3'b111;
        state_nxt = ADDIWB;
      end
      HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
        halted    = 1'b1;
        state_nxt = HALT;
`else
        // Unreachable in this build; recover to FETCH if ever entered.
        state_nxt = FETCH;
`endif
      end
    endcase

    // blt is taken on a nonzero compare result, beq on zero.
    pcen = pcwrite | (branch & zero) | (bltbranch & ~zero);

    // Reset low silences every output, even though the state reads FETCH.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      aluop    = 3'b000;
      halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. Each instruction
// pushes its expected per-cycle state and output vector; every cycle the
// bench pops one entry and compares it against the DUT.

module tb_mc_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BLT   = 6'b011000;
  localparam logic [5:0] OP_LI    = 6'b011001;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] outs;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite, iord, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       regdst, memtoreg;
  logic [2:0] aluop;
  logic [3:0] state;
  logic       halted;

  logic [15:0] outs;
  exp_t        sb[$];
  int          n_checks;
  int          n_errors;

  mc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .pcen     (pcen),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .memwrite (memwrite),
    .iord     (iord),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .aluop    (aluop),
    .state    (state),
    .halted   (halted)
  );

  assign outs = {pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb,
                 pcsrc, regdst, memtoreg, aluop, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference output vector for a state, straight from the state table.
  function automatic logic [15:0] model(input logic [3:0] s, input logic z);
    logic       e_pcen, e_irw, e_rw, e_mw, e_iord, e_asa, e_rd, e_m2r, e_hlt;
    logic [1:0] e_asb, e_pcs;
    logic [2:0] e_aop;
    e_pcen = 1'b0; e_irw = 1'b0; e_rw = 1'b0; e_mw = 1'b0; e_iord = 1'b0;
    e_asa = 1'b0; e_rd = 1'b0; e_m2r = 1'b0; e_hlt = 1'b0;
    e_asb = 2'b00; e_pcs = 2'b00; e_aop = 3'b000;
    case (s)
      4'd0:  begin e_irw = 1'b1; e_pcen = 1'b1; e_asb = 2'b01; end
      4'd1:  e_asb = 2'b11;
      4'd2:  begin e_asa = 1'b1; e_asb = 2'b10; end
      4'd3:  e_iord = 1'b1;
      4'd4:  begin e_rw = 1'b1; e_m2r = 1'b1; end
      4'd5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      4'd6:  begin e_asa = 1'b1; e_aop = 3'b010; end
      4'd7:  begin e_rw = 1'b1; e_rd = 1'b1; end
      4'd8:  begin e_asa = 1'b1; e_aop = 3'b001; e_pcs = 2'b01; e_pcen = z; end
      4'd9:  begin e_asa = 1'b1; e_asb = 2'b10; end
      4'd10: e_rw = 1'b1;
      4'd11: begin e_pcs = 2'b10; e_pcen = 1'b1; end
      4'd12: begin e_asa = 1'b1; e_asb = 2'b10; e_aop = 3'b011; end
      4'd13: begin e_asa = 1'b1; e_aop = 3'b110; e_pcs = 2'b01; e_pcen = ~z; end
      4'd14: begin e_asa = 1'b1; e_asb = 2'b10; e_aop = 3'b111; end
      default: e_hlt = 1'b1;
    endcase
    return {e_pcen, e_irw, e_rw, e_mw, e_iord, e_asa, e_asb, e_pcs, e_rd, e_m2r, e_aop, e_hlt};
  endfunction

  task automatic push_st(input logic [3:0] s, input logic z);
    exp_t e;
    e.st   = s;
    e.outs = model(s, z);
    sb.push_back(e);
  endtask

  // Expected state walk for one complete instruction.
  task automatic push_instr(input logic [5:0] o, input logic z);
    push_st(4'd0, z);
    push_st(4'd1, z);
    case (o)
      OP_LW:    begin push_st(4'd2, z); push_st(4'd3, z); push_st(4'd4, z); end
      OP_SW:    begin push_st(4'd2, z); push_st(4'd5, z); end
      OP_RTYPE: begin push_st(4'd6, z); push_st(4'd7, z); end
      OP_BEQ:   push_st(4'd8, z);
      OP_ADDI:  begin push_st(4'd9, z); push_st(4'd10, z); end
      OP_J:     push_st(4'd11, z);
      OP_LUI:   begin push_st(4'd12, z); push_st(4'd10, z); end
      OP_BLT:   push_st(4'd13, z);
      OP_LI:    begin push_st(4'd14, z); push_st(4'd10, z); end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) push_st(4'd15, z);
`endif
      end
    endcase
  endtask

  // Called at a negedge; drains the scoreboard one cycle per entry.
  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      #1;
      e = sb.pop_front();
      check($sformatf("op%b_st%0d_state", op, e.st), 32'(state), 32'(e.st));
      check($sformatf("op%b_st%0d_outs", op, e.st), 32'(outs), 32'(e.outs));
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z);
    op   = o;
    zero = z;
    push_instr(o, z);
    drain();
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_outs"}, 32'(outs), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    op       = OP_LW;
    zero     = 1'b0;

    repeat (2) @(negedge clk);
    #1 check_in_reset("reset_held");
    @(negedge clk);
    reset = 1'b1;

    run_instr(OP_LW, 1'b0);
    run_instr(OP_RTYPE, 1'b0);
    run_instr(OP_BEQ, 1'b1);
    run_instr(OP_BEQ, 1'b0);
    run_instr(OP_BLT, 1'b0);
    run_instr(OP_BLT, 1'b1);
    run_instr(OP_LUI, 1'b0);
    run_instr(OP_LI, 1'b1);
    run_instr(OP_ADDI, 1'b0);
    run_instr(OP_J, 1'b0);
    run_instr(OP_SW, 1'b1);

    // Abort a store in MEMWR: reset must clear memwrite and state at once.
    op   = OP_SW;
    zero = 1'b0;
    push_st(4'd0, 1'b0);
    push_st(4'd1, 1'b0);
    push_st(4'd2, 1'b0);
    push_st(4'd5, 1'b0);
    while (sb.size() > 1) begin
      exp_t e;
      #1;
      e = sb.pop_front();
      check($sformatf("abort_st%0d_state", e.st), 32'(state), 32'(e.st));
      check($sformatf("abort_st%0d_outs", e.st), 32'(outs), 32'(e.outs));
      @(negedge clk);
    end
    begin
      exp_t e;
      #1;
      e = sb.pop_front();
      check("abort_memwr_state", 32'(state), 32'(e.st));
      check("abort_memwr_memwrite", 32'(memwrite), 32'd1);
    end
    #1 reset = 1'b0;
    #1 check_in_reset("abort_async");
    check("abort_memwrite", 32'(memwrite), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_instr(OP_LW, 1'b0);

    // Illegal opcode: NOP in the default build, HALT when trapping.
    run_instr(OP_BAD, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    #1 reset = 1'b0;
    #1 check_in_reset("halt_cleared");
    @(negedge clk);
    reset = 1'b1;
`endif
    run_instr(OP_RTYPE, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard ceiling in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main control FSM for the single-core MIPS-style processor. Sequences each instruction through fetch/decode/execute/memory/writeback cycles from the 6-bit opcode and drives all datapath enables and mux selects. Produces the 3-bit `aluop` consumed directly by `aludec`, which combines it with `funct` to form `alucontrol`.

## Interface
- No parameters; widths fixed by ISA.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 6: opcode, instr[31:26], valid from DECODE onward.
- `zero` in 1: ALU zero flag, same cycle.
- `pcen` out 1: PC write enable.
- `irwrite` out 1: instruction register load.
- `regwrite` out 1: register file write.
- `memwrite` out 1: data memory write.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `alusrca` out 1: SrcA select, 0 = PC, 1 = A.
- `alusrcb` out 2: SrcB select, 00 B, 01 constant 4, 10 SignImm, 11 SignImm<<2.
- `pcsrc` out 2: PC source, 00 ALUResult, 01 ALUOut, 10 jump target.
- `regdst` out 1: destination, 0 = rt, 1 = rd.
- `memtoreg` out 1: writeback source, 0 = ALUOut, 1 = Data.
- `aluop` out 3: to `aludec`.
- `state` out 4: current state, debug.
- `halted` out 1: illegal-opcode halt flag (see Configuration).

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, lui 001111, blt 011000, li 011001.
- `aluop` encoding: 000 add, 001 sub, 010 R-type (funct), 011 lui, 110 blt, 111 li.
- States (encoding) -> asserted outputs; all unlisted outputs are 0:
  - FETCH 0: irwrite, pcwrite, alusrcb=01, aluop=000. Next: DECODE.
  - DECODE 1: alusrcb=11, aluop=000. Next by op: lw/sw -> MEMADR, R -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX, lui -> LUIEX, blt -> BLTEX, li -> LIEX, other -> illegal handling.
  - MEMADR 2: alusrca, alusrcb=10. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD 3: iord. Next: MEMWB.
  - MEMWB 4: regwrite, memtoreg. Next: FETCH.
  - MEMWR 5: iord, memwrite. Next: FETCH.
  - RTYPEEX 6: alusrca, aluop=010. Next: RTYPEWB.
  - RTYPEWB 7: regwrite, regdst. Next: FETCH.
  - BEQEX 8: alusrca, aluop=001, pcsrc=01, branch. Next: FETCH.
  - ADDIEX 9: alusrca, alusrcb=10. Next: ADDIWB.
  - ADDIWB 10: regwrite. Next: FETCH.
  - JEX 11: pcsrc=10, pcwrite. Next: FETCH.
  - LUIEX 12: alusrca, alusrcb=10, aluop=011. Next: ADDIWB.
  - BLTEX 13: alusrca, aluop=110, pcsrc=01, bltbranch. Next: FETCH.
  - LIEX 14: alusrca, alusrcb=10, aluop=111. Next: ADDIWB.
  - HALT 15: all outputs 0, `halted`=1. Self-loop.
- `pcen = pcwrite | (branch & zero) | (bltbranch & ~zero)`.
  - beq is taken when `zero`=1.
  - blt is taken when `zero`=0, because ALU op 0101 yields nonzero when rs<rt.
- `op` is sampled only in DECODE and MEMADR.

## Timing
- Outputs are Moore decodes of the state register, except `pcen`, which also depends combinationally on `zero`.
- Reset: `state` is forced to FETCH asynchronously.
  - While `reset`=0, all outputs are forced to 0, including `pcen`, `irwrite` and `aluop`=000.
  - The first rising edge after release is a FETCH cycle.
- Reset asserted mid-instruction aborts it immediately. There is no partial writeback after the assertion instant.
- Cycles per instruction:
  - 5: lw.
  - 4: sw, R-type, addi, lui, li.
  - 3: beq, blt, j.
- Back-to-back instructions need no idle cycles: the last state goes directly to FETCH.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unrecognised opcode in DECODE transitions to HALT.
  - `halted` stays 1 and all enables stay 0 until `reset` is asserted.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - An unrecognised opcode returns DECODE -> FETCH and behaves as a 2-cycle NOP with no writes.
  - HALT is unreachable and `halted` is tied to 0.

## Test plan
- Reset, then release with op=100011 (lw): states 0,1,2,3,4,0. `irwrite`=1 only in state 0; `regwrite`=`memtoreg`=1 in state 4; `aluop`=000 throughout.
- op=000000 (R-type): `aluop`=010 in state 6; `regwrite`=`regdst`=1 in state 7; 4 cycles total.
- op=000100 (beq):
  - `zero`=1 in state 8 -> `pcen`=1, `pcsrc`=01, `aluop`=001.
  - Repeat with `zero`=0 -> `pcen`=0.
- op=011000 (blt):
  - `zero`=0 -> `pcen`=1 with `aluop`=110.
  - op=001111 (lui) -> states 1,12,10 with `aluop`=011.
  - op=011001 (li) -> states 1,14,10 with `aluop`=111.
- Drive `reset`=0 during state 5 (sw): `memwrite` drops to 0 combinationally and `state`=0 without waiting for a clock edge.
- op=111111:
  - Macro defined -> state 15, `halted`=1, held 10 cycles, cleared only by reset.
  - Macro undefined -> back to state 0 after DECODE, no enables asserted.
